// File: rtl/pe_array_acc_if.sv
// Bus bundle for pe_array_acc: input beat channel and result channel.
// Handshake: a transfer happens on a rising clk edge where valid && ready;
// the sender holds its payload stable while valid is high and not yet taken.
interface pe_array_acc_if #(
   parameter int NUM_PE       = 4,
   parameter int DATA_NUM     = 4,
   parameter int DATA_WIDTH   = 16,
   parameter int WEIGHT_WIDTH = 4,
   parameter int RESULT_WIDTH = 32
);
   logic                                    in_valid;
   logic                                    in_ready;
   logic [NUM_PE*DATA_NUM*DATA_WIDTH-1:0]   in_data;
   logic [DATA_NUM*WEIGHT_WIDTH-1:0]        in_weight;
   logic                                    in_last;
   logic                                    signed_mode;
   logic                                    out_valid;
   logic                                    out_ready;
   logic [NUM_PE*RESULT_WIDTH-1:0]          out_result;
   logic [NUM_PE-1:0]                       out_sat;
   logic [15:0]                             out_beats;

   modport slave (
      input  in_valid, in_data, in_weight, in_last, signed_mode, out_ready,
      output in_ready, out_valid, out_result, out_sat, out_beats
   );

   modport master (
      output in_valid, in_data, in_weight, in_last, signed_mode, out_ready,
      input  in_ready, out_valid, out_result, out_sat, out_beats
   );
endinterface

// File: rtl/pe_array_acc.sv
// Array of NUM_PE dot-product PEs sharing one weight vector, with a
// saturating per-PE accumulator over groups of beats ended by in_last.
// Pipeline: stage 1 registers the full-precision dot products, stage 2
// accumulates and, on the last beat, loads the output registers.
// The whole pipe freezes while a finished result waits for out_ready.
module pe_array_acc #(
   parameter int NUM_PE       = 4,
   parameter int DATA_NUM     = 4,
   parameter int DATA_WIDTH   = 16,
   parameter int WEIGHT_WIDTH = 4,
   parameter int RESULT_WIDTH = 32
) (
   input logic            clk,
   input logic            rst_n,
   pe_array_acc_if.slave  io_bus
);
   localparam int SW = DATA_WIDTH + WEIGHT_WIDTH + $clog2(DATA_NUM);
   localparam int EW = ((RESULT_WIDTH > SW) ? RESULT_WIDTH : SW) + 2;

   function automatic logic signed [EW-1:0] f_ext_acc(input logic [RESULT_WIDTH-1:0] v,
                                                      input logic s);
      return s ? {{(EW-RESULT_WIDTH){v[RESULT_WIDTH-1]}}, v} : {{(EW-RESULT_WIDTH){1'b0}}, v};
   endfunction

   function automatic logic signed [EW-1:0] f_ext_dot(input logic [SW-1:0] v, input logic s);
      return s ? {{(EW-SW){v[SW-1]}}, v} : {{(EW-SW){1'b0}}, v};
   endfunction

   logic                    w_stall, w_accept, w_first, w_mode;
   logic                    r_in_group, r_grp_signed;
   logic                    r_s1_valid, r_s1_first, r_s1_last, r_s1_signed;
   logic [SW-1:0]           w_dot [NUM_PE];
   logic [SW-1:0]           r_s1_dot [NUM_PE];
   logic [RESULT_WIDTH-1:0] r_acc [NUM_PE];
   logic [RESULT_WIDTH-1:0] w_new_acc [NUM_PE];
   logic [NUM_PE-1:0]       r_sat, w_new_sat;
   logic [15:0]             r_beats, w_new_beats;
   logic                    r_out_valid;
   logic [NUM_PE*RESULT_WIDTH-1:0] r_out_result;
   logic [NUM_PE-1:0]       r_out_sat;
   logic [15:0]             r_out_beats;

   // A held result blocks everything upstream, so in_ready is just !stall.
   assign w_stall         = r_out_valid && !io_bus.out_ready;
   assign w_accept        = io_bus.in_valid && !w_stall;
   assign io_bus.in_ready = !w_stall;
   assign w_first         = !r_in_group;
   // The first beat's mode governs the whole group.
   assign w_mode          = w_first ? io_bus.signed_mode : r_grp_signed;

   // Track whether a group is open and latch its operand mode on the first beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_group   <= 1'b0;
         r_grp_signed <= 1'b0;
      end else if (w_accept) begin
         r_in_group <= !io_bus.in_last;
         if (w_first) r_grp_signed <= io_bus.signed_mode;
      end
   end

   // Per-PE dot product of DATA_NUM elements, operands extended per mode.
   always_comb begin : dot_comb
      logic signed [SW-1:0] v_d, v_w, v_sum;
      v_d   = '0;
      v_w   = '0;
      v_sum = '0;
      for (int p = 0; p < NUM_PE; p++) begin
         v_sum = '0;
         for (int k = 0; k < DATA_NUM; k++) begin
            if (w_mode) begin
               v_d = SW'($signed(io_bus.in_data[(p*DATA_NUM+k)*DATA_WIDTH +: DATA_WIDTH]));
               v_w = SW'($signed(io_bus.in_weight[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
            end else begin
               v_d = SW'(io_bus.in_data[(p*DATA_NUM+k)*DATA_WIDTH +: DATA_WIDTH]);
               v_w = SW'(io_bus.in_weight[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
            end
            v_sum = v_sum + v_d * v_w;
         end
         w_dot[p] = v_sum;
      end
   end

   // Stage 1 register: dot products plus group markers; idle cycles become bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_first  <= 1'b0;
         r_s1_last   <= 1'b0;
         r_s1_signed <= 1'b0;
         for (int p = 0; p < NUM_PE; p++) r_s1_dot[p] <= '0;
      end else if (!w_stall) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_first  <= w_first;
            r_s1_last   <= io_bus.in_last;
            r_s1_signed <= w_mode;
            for (int p = 0; p < NUM_PE; p++) r_s1_dot[p] <= w_dot[p];
         end
      end
   end

   // Saturating add (or load on a first beat) into each PE accumulator.
   always_comb begin : acc_comb
      logic signed [EW-1:0] v_tot, v_hi, v_lo;
      v_hi = r_s1_signed ? {{(EW-RESULT_WIDTH+1){1'b0}}, {(RESULT_WIDTH-1){1'b1}}}
                         : {{(EW-RESULT_WIDTH){1'b0}}, {RESULT_WIDTH{1'b1}}};
      v_lo = r_s1_signed ? {{(EW-RESULT_WIDTH+1){1'b1}}, {(RESULT_WIDTH-1){1'b0}}}
                         : '0;
      v_tot     = '0;
      w_new_sat = '0;
      for (int p = 0; p < NUM_PE; p++) begin
         v_tot = (r_s1_first ? '0 : f_ext_acc(r_acc[p], r_s1_signed))
               + f_ext_dot(r_s1_dot[p], r_s1_signed);
         w_new_sat[p] = r_s1_first ? 1'b0 : r_sat[p];
         if (v_tot > v_hi) begin
            w_new_acc[p] = v_hi[RESULT_WIDTH-1:0];
            w_new_sat[p] = 1'b1;
         end else if (v_tot < v_lo) begin
            w_new_acc[p] = v_lo[RESULT_WIDTH-1:0];
            w_new_sat[p] = 1'b1;
         end else begin
            w_new_acc[p] = v_tot[RESULT_WIDTH-1:0];
         end
      end
      w_new_beats = r_s1_first ? 16'd1 : ((r_beats == 16'hFFFF) ? r_beats : r_beats + 16'd1);
   end

   // Stage 2 accumulator, sticky saturation flags and beat counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < NUM_PE; p++) r_acc[p] <= '0;
         r_sat   <= '0;
         r_beats <= '0;
      end else if (!w_stall && r_s1_valid) begin
         for (int p = 0; p < NUM_PE; p++) r_acc[p] <= w_new_acc[p];
         r_sat   <= w_new_sat;
         r_beats <= w_new_beats;
      end
   end

   // Output register: loads on a group's last beat, clears once taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_sat    <= '0;
         r_out_beats  <= '0;
      end else if (!w_stall) begin
         if (r_s1_valid && r_s1_last) begin
            r_out_valid <= 1'b1;
            for (int p = 0; p < NUM_PE; p++)
               r_out_result[p*RESULT_WIDTH +: RESULT_WIDTH] <= w_new_acc[p];
            r_out_sat   <= w_new_sat;
            r_out_beats <= w_new_beats;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign io_bus.out_valid  = r_out_valid;
   assign io_bus.out_result = r_out_result;
   assign io_bus.out_sat    = r_out_sat;
   assign io_bus.out_beats  = r_out_beats;
endmodule

// File: tb/tb_pe_array_acc.sv
// Bench for pe_array_acc: two instances (32-bit and 20-bit results) share
// identical stimulus; a plain-arithmetic group model fills expected queues.
module tb_pe_array_acc;
   localparam int NP  = 4;
   localparam int DN  = 4;
   localparam int DW  = 16;
   localparam int WW  = 4;
   localparam int RWA = 32;
   localparam int RWB = 20;
   localparam int VA  = NP*RWA + NP + 16;
   localparam int VB  = NP*RWB + NP + 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic                   in_valid, in_last, signed_mode, out_ready;
   logic [NP*DN*DW-1:0]    in_data;
   logic [DN*WW-1:0]       in_weight;

   pe_array_acc_if #(.NUM_PE(NP), .DATA_NUM(DN), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
                     .RESULT_WIDTH(RWA)) bus_a ();
   pe_array_acc_if #(.NUM_PE(NP), .DATA_NUM(DN), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
                     .RESULT_WIDTH(RWB)) bus_b ();

   assign bus_a.in_valid = in_valid;    assign bus_b.in_valid = in_valid;
   assign bus_a.in_last = in_last;      assign bus_b.in_last = in_last;
   assign bus_a.signed_mode = signed_mode; assign bus_b.signed_mode = signed_mode;
   assign bus_a.out_ready = out_ready;  assign bus_b.out_ready = out_ready;
   assign bus_a.in_data = in_data;      assign bus_b.in_data = in_data;
   assign bus_a.in_weight = in_weight;  assign bus_b.in_weight = in_weight;

   pe_array_acc #(.NUM_PE(NP), .DATA_NUM(DN), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
                  .RESULT_WIDTH(RWA)) dut_a (.clk(clk), .rst_n(rst_n), .io_bus(bus_a));
   pe_array_acc #(.NUM_PE(NP), .DATA_NUM(DN), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
                  .RESULT_WIDTH(RWB)) dut_b (.clk(clk), .rst_n(rst_n), .io_bus(bus_b));

   // ---------------- scoreboard ----------------
   logic [VA-1:0] exp_qa[$];
   logic [VB-1:0] exp_qb[$];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   longint m_acc_a[NP], m_acc_b[NP];
   bit     m_sat_a[NP], m_sat_b[NP];
   int     m_beats;
   bit     m_in_group, m_mode;

   function automatic longint as_num(input longint raw, input int w, input bit s);
      longint m;
      m = raw & ((longint'(1) << w) - 1);
      if (s && (((m >> (w-1)) & 1) == 1)) return m - (longint'(1) << w);
      return m;
   endfunction

   function automatic longint clamp(input longint v, input int rw, input bit s, output bit hit);
      longint hi, lo;
      hi = s ? (longint'(1) << (rw-1)) - 1 : (longint'(1) << rw) - 1;
      lo = s ? -(longint'(1) << (rw-1)) : 0;
      hit = (v > hi) || (v < lo);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   task automatic model_accept();
      bit first, hit;
      longint dot;
      logic [VA-1:0] va;
      logic [VB-1:0] vb;
      first = !m_in_group;
      if (first) begin
         m_mode  = signed_mode;
         m_beats = 0;
         for (int p = 0; p < NP; p++) begin m_sat_a[p] = 0; m_sat_b[p] = 0; end
      end
      m_beats = (m_beats < 65535) ? m_beats + 1 : 65535;
      for (int p = 0; p < NP; p++) begin
         dot = 0;
         for (int k = 0; k < DN; k++)
            dot += as_num(longint'(in_data[(p*DN+k)*DW +: DW]), DW, m_mode)
                 * as_num(longint'(in_weight[k*WW +: WW]), WW, m_mode);
         m_acc_a[p] = clamp((first ? 0 : m_acc_a[p]) + dot, RWA, m_mode, hit);
         m_sat_a[p] |= hit;
         m_acc_b[p] = clamp((first ? 0 : m_acc_b[p]) + dot, RWB, m_mode, hit);
         m_sat_b[p] |= hit;
      end
      if (in_last) begin
         va = '0;
         vb = '0;
         for (int p = 0; p < NP; p++) begin
            va[p*RWA +: RWA] = m_acc_a[p][RWA-1:0];
            vb[p*RWB +: RWB] = m_acc_b[p][RWB-1:0];
            va[NP*RWA + p]   = m_sat_a[p];
            vb[NP*RWB + p]   = m_sat_b[p];
         end
         va[NP*RWA+NP +: 16] = m_beats[15:0];
         vb[NP*RWB+NP +: 16] = m_beats[15:0];
         exp_qa.push_back(va);
         exp_qb.push_back(vb);
         m_in_group = 0;
      end else begin
         m_in_group = 1;
      end
   endtask

   // ---------------- driver tasks ----------------
   int hold_n = 0;
   bit rand_rdy = 0;
   bit accepted;
   int rejected = 0;

   task automatic monitor();
      accepted = 0;
      chk("in_ready_a", bus_a.in_ready, !(bus_a.out_valid && !out_ready));
      chk("in_ready_b", bus_b.in_ready, !(bus_b.out_valid && !out_ready));
      if (bus_a.out_valid) begin
         chk("pending_a", exp_qa.size() != 0, 1);
         if (exp_qa.size() != 0) begin
            chk("out_a", {bus_a.out_beats, bus_a.out_sat, bus_a.out_result}, exp_qa[0]);
            if (out_ready) void'(exp_qa.pop_front());
         end
      end
      if (bus_b.out_valid) begin
         chk("pending_b", exp_qb.size() != 0, 1);
         if (exp_qb.size() != 0) begin
            chk("out_b", {bus_b.out_beats, bus_b.out_sat, bus_b.out_result}, exp_qb[0]);
            if (out_ready) void'(exp_qb.pop_front());
         end
      end
      if (in_valid && bus_a.in_ready) begin
         model_accept();
         accepted = 1;
      end else if (in_valid) begin
         rejected++;
      end
   endtask

   task automatic step(input bit v, input bit last, input bit mode,
                       input logic [NP*DN*DW-1:0] d, input logic [DN*WW-1:0] w);
      @(negedge clk);
      in_valid    = v;
      in_last     = last;
      signed_mode = mode;
      in_data     = d;
      in_weight   = w;
      if (hold_n > 0) begin
         out_ready = 1'b0;
         hold_n--;
      end else begin
         out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      #1;
      monitor();
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic send_beat(input logic [NP*DN*DW-1:0] d, input logic [DN*WW-1:0] w,
                            input bit last, input bit mode);
      int tries;
      tries = 0;
      do begin
         step(1'b1, last, mode, d, w);
         tries++;
      end while (!accepted && tries < 200);
      chk("send_accepted", accepted, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      rand_rdy = 0;
      while ((exp_qa.size() != 0 || exp_qb.size() != 0) && n < 100) begin
         idle();
         n++;
      end
      chk("drain_a", exp_qa.size(), 0);
      chk("drain_b", exp_qb.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      #1;
      chk("rst_valid_a", bus_a.out_valid, 0);
      chk("rst_result_a", bus_a.out_result, 0);
      chk("rst_sat_a", bus_a.out_sat, 0);
      chk("rst_beats_a", bus_a.out_beats, 0);
      chk("rst_valid_b", bus_b.out_valid, 0);
      chk("rst_in_ready", bus_a.in_ready, 1);
      exp_qa.delete();
      exp_qb.delete();
      m_in_group = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready_after", bus_a.in_ready, 1);
   endtask

   function automatic logic [NP*DN*DW-1:0] fill(input logic [DW-1:0] v);
      logic [NP*DN*DW-1:0] r;
      for (int i = 0; i < NP*DN; i++) r[i*DW +: DW] = v;
      return r;
   endfunction

   function automatic logic [DN*WW-1:0] wvec(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                                             input logic [WW-1:0] w2, input logic [WW-1:0] w3);
      return {w3, w2, w1, w0};
   endfunction

   function automatic logic [NP*DN*DW-1:0] rand_data();
      logic [NP*DN*DW-1:0] r;
      for (int i = 0; i < NP*DN; i++) begin
         case ($urandom_range(0, 7))
            0:       r[i*DW +: DW] = 16'hFFFF;
            1:       r[i*DW +: DW] = 16'h8000;
            2:       r[i*DW +: DW] = 16'h7FFF;
            3:       r[i*DW +: DW] = 16'h0000;
            default: r[i*DW +: DW] = DW'($urandom);
         endcase
      end
      return r;
   endfunction

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [DN*WW-1:0] w1234;
      rst_n = 1'b0; in_valid = 0; in_last = 0; signed_mode = 0; out_ready = 1;
      in_data = '0; in_weight = '0;
      w1234 = wvec(4'd1, 4'd2, 4'd3, 4'd4);
      do_reset();

      // single unsigned beat, latency t+2
      send_beat(fill(16'd1000), w1234, 1, 0);
      idle();
      chk("lat_t1_valid", bus_a.out_valid, 0);
      idle();
      chk("lat_t2_valid", bus_a.out_valid, 1);
      chk("single_res_p0", bus_a.out_result[31:0], 10000);
      chk("single_res_p3", bus_a.out_result[127:96], 10000);
      chk("single_sat", bus_a.out_sat, 0);
      chk("single_beats", bus_a.out_beats, 1);

      // all-ones data and weights, signed then unsigned
      send_beat(fill(16'hFFFF), wvec(4'hF, 4'hF, 4'hF, 4'hF), 1, 1);
      idle(); idle();
      chk("ones_signed", bus_a.out_result[63:32], 4);
      send_beat(fill(16'hFFFF), wvec(4'hF, 4'hF, 4'hF, 4'hF), 1, 0);
      idle(); idle();
      chk("ones_unsigned", bus_a.out_result[95:64], 3932100);
      chk("ones_unsigned_sat_b", bus_b.out_sat, 4'hF);

      // three-beat group, one output pulse
      send_beat(fill(16'd1000), w1234, 0, 0);
      send_beat(fill(16'd1000), w1234, 0, 1);
      send_beat(fill(16'd1000), w1234, 1, 1);
      idle(); idle();
      chk("group3_res", bus_a.out_result[31:0], 30000);
      chk("group3_beats", bus_a.out_beats, 3);
      idle();
      chk("group3_single_pulse", bus_a.out_valid, 0);

      // signed saturation in the 20-bit instance
      send_beat(fill(16'd32767), wvec(4'd7, 4'd7, 4'd7, 4'd7), 0, 1);
      send_beat(fill(16'd32767), wvec(4'd7, 4'd7, 4'd7, 4'd7), 1, 1);
      idle(); idle();
      chk("sat20_res_p0", bus_b.out_result[19:0], 524287);
      chk("sat20_res_p3", bus_b.out_result[79:60], 524287);
      chk("sat20_flags", bus_b.out_sat, 4'hF);
      chk("sat20_wide_res", bus_a.out_result[31:0], 1834952);

      // five stalled cycles with a beat waiting
      hold_n = 7;
      send_beat(fill(16'd1000), w1234, 1, 0);
      idle();
      rejected = 0;
      send_beat(fill(16'd2000), w1234, 1, 0);
      chk("stall_rejected", rejected, 5);
      idle(); idle();
      chk("after_stall_res", bus_a.out_result[31:0], 20000);
      drain();

      // reset in the middle of a group
      send_beat(fill(16'd1000), w1234, 0, 0);
      send_beat(fill(16'd1000), w1234, 0, 0);
      do_reset();
      send_beat(fill(16'd1000), w1234, 1, 0);
      idle(); idle();
      chk("post_reset_res", bus_a.out_result[31:0], 10000);
      chk("post_reset_beats", bus_a.out_beats, 1);

      // randomized traffic with random backpressure
      rand_rdy = 1;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 19) == 0) hold_n = $urandom_range(1, 6);
         if ($urandom_range(0, 4) == 0)
            idle();
         else
            send_beat(rand_data(), DN*WW'($urandom), $urandom_range(0, 2) == 0,
                      $urandom_range(0, 1) == 1);
      end
      // close any open group so every queued result is delivered
      send_beat(rand_data(), DN*WW'($urandom), 1, 0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
